// File: rtl/fft_addr_gen_if.sv
// Bundle between the FFT control/datapath side and the address generator.
//
// Handshake: the generator raises addr_valid together with a complete address set
// (a_*, b_*, tw_idx, stage). An address set is consumed on every rising clk edge where
// addr_valid && addr_ready. While addr_valid is high and addr_ready is low, the generator
// holds every output stable. addr_ready is ignored while addr_valid is low. addr_valid
// never depends on addr_ready in the same cycle.
interface fft_addr_gen_if #(
    parameter int LOG2N  = 8,
    parameter int ADDR_W = LOG2N + 1
);
    // control side -> generator
    logic              start;
    logic [1:0]        mode;
    logic              abort;
    logic              addr_ready;

    // generator -> control/datapath side
    logic              addr_valid;
    logic [ADDR_W-1:0] a_real;
    logic [ADDR_W-1:0] a_imag;
    logic [ADDR_W-1:0] b_real;
    logic [ADDR_W-1:0] b_imag;
    logic [LOG2N-2:0]  tw_idx;
    logic [3:0]        stage;
    logic              busy;
    logic              done;

    // Control FSM / datapath view
    modport master (
        output start, mode, abort, addr_ready,
        input  addr_valid, a_real, a_imag, b_real, b_imag, tw_idx, stage, busy, done
    );

    // Address generator view
    modport slave (
        input  start, mode, abort, addr_ready,
        output addr_valid, a_real, a_imag, b_real, b_imag, tw_idx, stage, busy, done
    );
endinterface

// File: rtl/fft_addr_gen.sv
// Address sequencer for an in-place radix-2 DIF FFT.
// Three phases: natural-order load, butterfly compute (A/B pair + twiddle index),
// bit-reversed unload. Real bank lives at [0,N), imag bank at [N,2N).
// All outputs are registered; the next address set is computed combinationally from
// the next counter values and loaded on start or on each handshake.
module fft_addr_gen #(
    parameter int LOG2N  = 8,
    parameter int ADDR_W = LOG2N + 1
) (
    input  logic                 clk,
    input  logic                 nrst,
    fft_addr_gen_if.slave        bus,
    output logic [2:0]           state_o
);

    localparam int N    = 1 << LOG2N;
    localparam int TW_W = LOG2N - 1;

    localparam logic [LOG2N-1:0]  K_LAST   = '1;
    localparam logic [TW_W-1:0]   J_LAST   = '1;
    localparam logic [3:0]        S_LAST   = 4'(LOG2N - 1);
    // Imag address = real address with bit LOG2N set (real addresses are always < N)
    localparam logic [ADDR_W-1:0] IMAG_BIT = ADDR_W'(N);

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_LOAD = 3'd1,
        ST_COMP = 3'd2,
        ST_UNLD = 3'd3,
        ST_DONE = 3'd4
    } state_t;

    // ------------------------------------------------------------------
    // State and counters
    // ------------------------------------------------------------------
    state_t            state_q;
    logic [LOG2N-1:0]  k_q;      // LOAD/UNLD sample counter
    logic [3:0]        s_q;      // COMP stage counter
    logic [TW_W-1:0]   j_q;      // COMP butterfly counter

    // Registered outputs
    logic              addr_valid_q;
    logic [ADDR_W-1:0] a_real_q;
    logic [ADDR_W-1:0] a_imag_q;
    logic [ADDR_W-1:0] b_real_q;
    logic [ADDR_W-1:0] b_imag_q;
    logic [TW_W-1:0]   tw_q;
    logic [3:0]        stage_q;
    logic              busy_q;
    logic              done_q;

    // Next counter values and the phase they belong to
    state_t            sel_d;
    logic [LOG2N-1:0]  k_d;
    logic [3:0]        s_d;
    logic [TW_W-1:0]   j_d;

    // Next address set
    logic [ADDR_W-1:0] a_real_d;
    logic [ADDR_W-1:0] b_real_d;
    logic [TW_W-1:0]   tw_d;

    // Compute-phase arithmetic scratch
    logic [31:0]       s_i;
    logic [31:0]       j_i;
    logic [31:0]       span_i;
    logic [31:0]       p_i;
    logic [31:0]       g_i;
    logic [31:0]       ca_i;
    logic [31:0]       tw_i;
    logic [LOG2N-1:0]  br_k;

    logic              hs;
    logic              last_k;
    logic              last_c;

    assign hs     = addr_valid_q & bus.addr_ready;
    assign last_k = (k_q == K_LAST);
    assign last_c = (s_q == S_LAST) && (j_q == J_LAST);

    // Next counters: zero when a phase is being entered, advance by one on a handshake
    always_comb begin
        sel_d = state_q;
        k_d   = k_q;
        s_d   = s_q;
        j_d   = j_q;
        if (state_q == ST_IDLE) begin
            k_d = '0;
            s_d = '0;
            j_d = '0;
            unique case (bus.mode)
                2'b01:   sel_d = ST_LOAD;
                2'b10:   sel_d = ST_COMP;
                2'b11:   sel_d = ST_UNLD;
                default: sel_d = ST_IDLE;
            endcase
        end else if (hs) begin
            k_d = k_q + LOG2N'(1);
            if (j_q == J_LAST) begin
                j_d = '0;
                s_d = s_q + 4'd1;
            end else begin
                j_d = j_q + TW_W'(1);
            end
        end
    end

    // Address set for the next counter values in the selected phase
    always_comb begin
        br_k = '0;
        for (int i = 0; i < LOG2N; i++) begin
            br_k[i] = k_d[LOG2N-1-i];
        end

        // Butterfly pair: span halves each stage, g selects the group, p the offset
        s_i    = 32'(s_d);
        j_i    = 32'(j_d);
        span_i = 32'(N) >> (s_i + 32'd1);
        p_i    = j_i & (span_i - 32'd1);
        g_i    = j_i >> (32'(LOG2N) - 32'd1 - s_i);
        ca_i   = (g_i * 32'd2 * span_i) + p_i;
        tw_i   = p_i << s_i;

        a_real_d = '0;
        b_real_d = '0;
        tw_d     = '0;
        unique case (sel_d)
            ST_LOAD: begin
                a_real_d = ADDR_W'(k_d);
                b_real_d = ADDR_W'(k_d);
            end
            ST_UNLD: begin
                a_real_d = ADDR_W'(br_k);
                b_real_d = ADDR_W'(br_k);
            end
            ST_COMP: begin
                a_real_d = ADDR_W'(ca_i);
                b_real_d = ADDR_W'(ca_i + span_i);
                tw_d     = TW_W'(tw_i);
            end
            default: begin
                a_real_d = '0;
                b_real_d = '0;
                tw_d     = '0;
            end
        endcase
    end

    // Phase FSM with registered outputs; abort wins over handshake and start
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state_q      <= ST_IDLE;
            k_q          <= '0;
            s_q          <= '0;
            j_q          <= '0;
            addr_valid_q <= 1'b0;
            a_real_q     <= '0;
            a_imag_q     <= '0;
            b_real_q     <= '0;
            b_imag_q     <= '0;
            tw_q         <= '0;
            stage_q      <= '0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
        end else if (bus.abort) begin
            state_q      <= ST_IDLE;
            k_q          <= '0;
            s_q          <= '0;
            j_q          <= '0;
            addr_valid_q <= 1'b0;
            a_real_q     <= '0;
            a_imag_q     <= '0;
            b_real_q     <= '0;
            b_imag_q     <= '0;
            tw_q         <= '0;
            stage_q      <= '0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    done_q <= 1'b0;
                    // mode 00 decodes to ST_IDLE and is ignored
                    if (bus.start && (sel_d != ST_IDLE)) begin
                        state_q      <= sel_d;
                        k_q          <= k_d;
                        s_q          <= s_d;
                        j_q          <= j_d;
                        addr_valid_q <= 1'b1;
                        busy_q       <= 1'b1;
                        a_real_q     <= a_real_d;
                        a_imag_q     <= a_real_d | IMAG_BIT;
                        b_real_q     <= b_real_d;
                        b_imag_q     <= b_real_d | IMAG_BIT;
                        tw_q         <= tw_d;
                        stage_q      <= '0;
                    end
                end

                ST_LOAD, ST_UNLD, ST_COMP: begin
                    if (hs) begin
                        if ((state_q == ST_COMP) ? last_c : last_k) begin
                            // Final set consumed: one-cycle DONE, outputs back to idle values
                            state_q      <= ST_DONE;
                            k_q          <= '0;
                            s_q          <= '0;
                            j_q          <= '0;
                            addr_valid_q <= 1'b0;
                            done_q       <= 1'b1;
                            a_real_q     <= '0;
                            a_imag_q     <= '0;
                            b_real_q     <= '0;
                            b_imag_q     <= '0;
                            tw_q         <= '0;
                            stage_q      <= '0;
                        end else begin
                            k_q      <= k_d;
                            s_q      <= s_d;
                            j_q      <= j_d;
                            a_real_q <= a_real_d;
                            a_imag_q <= a_real_d | IMAG_BIT;
                            b_real_q <= b_real_d;
                            b_imag_q <= b_real_d | IMAG_BIT;
                            tw_q     <= tw_d;
                            stage_q  <= (state_q == ST_COMP) ? s_d : 4'd0;
                        end
                    end
                end

                ST_DONE: begin
                    state_q <= ST_IDLE;
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                end

                default: begin
                    state_q      <= ST_IDLE;
                    addr_valid_q <= 1'b0;
                    busy_q       <= 1'b0;
                    done_q       <= 1'b0;
                end
            endcase
        end
    end

    assign bus.addr_valid = addr_valid_q;
    assign bus.a_real     = a_real_q;
    assign bus.a_imag     = a_imag_q;
    assign bus.b_real     = b_real_q;
    assign bus.b_imag     = b_imag_q;
    assign bus.tw_idx     = tw_q;
    assign bus.stage      = stage_q;
    assign bus.busy       = busy_q;
    assign bus.done       = done_q;
    assign state_o        = state_q;

endmodule
